// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM encoding,
// jump opcode constants and the default reset PC.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [5:0]  OPCODE_J     = 6'h02;
  // JR is R-type; this is its funct-field code.
  localparam logic [5:0]  OPCODE_JR    = 6'h08;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/jump_target_gen.sv
// Combinational redirect-target builder: J-type and branch targets,
// both relative to pc_plus4 (delay-slot PC), not the fetch PC.
module jump_target_gen
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] jump_index_i,
  input  logic [15:0] branch_offset_i,
  output logic [31:0] jump_tgt_o,
  output logic [31:0] branch_tgt_o
);

  assign jump_tgt_o   = {pc_plus4_i[31:28], jump_index_i, 2'b00};
  assign branch_tgt_o = pc_plus4_i + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: holds the PC, offers it to instruction memory over
// valid/ready, and resolves sequential / branch / jump / jr redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jr_req,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              jump_req,
  input  logic [25:0]       jump_index,
  input  logic              branch_req,
  input  logic [15:0]       branch_offset,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_pend,
  output logic              align_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_q, pend_d;
  logic              align_q, align_d;

  logic [ADDR_W-1:0] jump_tgt, branch_tgt, req_tgt;
  logic              run, accept, req, jr_bad;

  assign pc_plus4 = pc_q + 32'd4;

  jump_target_gen u_tgt (
    .pc_plus4_i      (pc_plus4),
    .jump_index_i    (jump_index),
    .branch_offset_i (branch_offset),
    .jump_tgt_o      (jump_tgt),
    .branch_tgt_o    (branch_tgt)
  );

  assign run     = (state_q == ST_RUN);
  assign accept  = run & imem_ready & ~stall;
  assign req     = run & (jr_req | jump_req | branch_req);
  assign jr_bad  = run & jr_req & (jr_target[1:0] != 2'b00);
  assign req_tgt = jr_req ? jr_target : (jump_req ? jump_tgt : branch_tgt);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    align_d    = align_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (jr_bad) begin
          // Misaligned jr is fatal: freeze the PC and drop any pending redirect.
          state_d = ST_HALT;
          align_d = 1'b1;
          pend_d  = 1'b0;
        end else if (accept) begin
          if (req)         pc_d = req_tgt;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = pc_plus4;
          pend_d = 1'b0;
        end else if (req) begin
          // Latest request wins over whatever is already latched.
          pend_tgt_d = req_tgt;
          pend_d     = 1'b1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_q     <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
      align_q    <= align_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = run;
  assign redirect_pend = pend_q;
  assign align_err     = align_q;

endmodule
